// File: rtl/alu_gen_pkg.sv
// alu_gen_pkg: opcode, sequencer-phase and shift-mode constants shared by
// the alu_gen top level and its multiplier.
package alu_gen_pkg;

  // Opcodes carried in instruction[7:5]
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_NAND  = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b011;
  localparam logic [2:0] OP_LD    = 3'b100;
  localparam logic [2:0] OP_ST    = 3'b101;
  localparam logic [2:0] OP_MUL   = 3'b110;
  localparam logic [2:0] OP_ADC   = 3'b111;

  // Sequencer phases driven by the CPU core
  localparam logic [1:0] FETCH  = 2'b00;
  localparam logic [1:0] DECODE = 2'b01;
  localparam logic [1:0] EXEC_A = 2'b10;
  localparam logic [1:0] EXEC_B = 2'b11;

  // instruction[4:0] value selecting a right shift; any other value shifts left
  localparam logic [4:0] SHIFT_RIGHT_CODE = 5'h1F;

  // Opcodes that produce a result in EXEC_A and write it back in EXEC_B
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) ||
           (op == OP_SHIFT) || (op == OP_ADC);
  endfunction

endpackage

// File: rtl/alu_gen_mul.sv
// alu_gen_mul: iterative WIDTH x WIDTH unsigned shift-add multiplier.
// Handshake: i_start is accepted only while o_busy is low; o_busy then stays
// high for exactly WIDTH cycles. o_done is high in the final busy cycle, and
// o_product carries the complete product in that same cycle, so the parent
// can capture it on the edge where o_busy falls. o_cnt exposes the
// remaining-iteration counter for observation.
module alu_gen_mul
  import alu_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product,
  output logic [CW-1:0]      o_cnt
);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_prod_next;

  // Partial product after the current iteration's conditional add
  assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

  // Load operands on start, then one shift-add step per cycle for WIDTH cycles
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_prod   <= '0;
      r_mplier <= i_b;
      r_cnt    <= CW'(WIDTH);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == CW'(1));
  assign o_product = w_prod_next;
  assign o_cnt     = r_cnt;

endmodule

// File: rtl/alu_gen.sv
// alu_gen: WIDTH-bit accumulator ALU for the four-phase CPU sequencer.
// Results and flags land in latch at the end of EXEC_A and are written back
// to acc at the end of EXEC_B. Optional feature macro: ALU_MUL_EN adds the
// iterative multiplier (opcode 110), prod_hi and busy; without it opcode 110
// is a NOP and busy/prod_hi are tied low.
module alu_gen
  import alu_gen_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             tclk,
  input  logic             reset_n,
  input  logic [7:0]       instruction,
  input  logic [1:0]       state,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             d_oe,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] latch,
  output logic [WIDTH-1:0] prod_hi,
  output logic             c,
  output logic             z,
  output logic             n,
  output logic             v,
  output logic             busy
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_latch;
  logic             r_c;
  logic             r_z;
  logic             r_n;
  logic             r_v;

  logic [2:0]       w_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;
  logic             w_busy;

  assign w_op = instruction[7:5];

  // Carry-in only participates for ADC; the extra MSB of each sum is carry/borrow
  assign w_sum  = {1'b0, r_acc} + {1'b0, d_in} +
                  {{WIDTH{1'b0}}, (w_op == OP_ADC) & r_c};
  assign w_diff = {1'b0, r_acc} - {1'b0, d_in};

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]   r_prod_hi;
  logic               r_wb_pend;
  logic               w_mul_start;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;
  logic [CW-1:0]      w_mul_cnt;

  assign w_mul_start = (state == EXEC_A) && (w_op == OP_MUL) && !w_busy;

  alu_gen_mul #(.WIDTH(WIDTH)) u_mul (
    .i_clk     (tclk),
    .i_rst_n   (reset_n),
    .i_start   (w_mul_start),
    .i_a       (r_acc),
    .i_b       (d_in),
    .o_busy    (w_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod),
    .o_cnt     (w_mul_cnt)
  );

  assign prod_hi = r_prod_hi;
`else
  assign w_busy  = 1'b0;
  assign prod_hi = '0;
`endif

  // Single-cycle result and carry/overflow for the ALU opcodes
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ADD, OP_ADC: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_acc[WIDTH-1] == d_in[WIDTH-1]) &&
                (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_c   = w_diff[WIDTH];
        w_v   = (r_acc[WIDTH-1] != d_in[WIDTH-1]) &&
                (w_diff[WIDTH-1] != r_acc[WIDTH-1]);
      end
      OP_NAND: begin
        w_res = ~(r_acc & d_in);
      end
      OP_SHIFT: begin
        if (instruction[4:0] == SHIFT_RIGHT_CODE) begin
          w_res = {1'b0, r_acc[WIDTH-1:1]};
          w_c   = r_acc[0];
        end else begin
          w_res = {r_acc[WIDTH-2:0], 1'b0};
          w_c   = r_acc[WIDTH-1];
        end
      end
      default: begin
      end
    endcase
  end

  // Register updates: EXEC_A compute/LD, EXEC_B write-back, multiply completion
  always_ff @(posedge tclk) begin
    if (!reset_n) begin
      r_acc   <= '0;
      r_latch <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
`ifdef ALU_MUL_EN
      r_prod_hi <= '0;
      r_wb_pend <= 1'b0;
`endif
    end else begin
      if (state == EXEC_A && !w_busy) begin
        if (is_alu_op(w_op)) begin
          r_latch <= w_res;
          r_c     <= w_c;
          r_v     <= w_v;
          r_z     <= (w_res == '0);
          r_n     <= w_res[WIDTH-1];
        end else if (w_op == OP_LD) begin
          r_acc <= d_in;
        end
      end
      if (state == EXEC_B && !w_busy && is_alu_op(w_op)) begin
        r_acc <= r_latch;
      end
`ifdef ALU_MUL_EN
      if (w_mul_done) begin
        r_latch   <= w_mul_prod[WIDTH-1:0];
        r_prod_hi <= w_mul_prod[2*WIDTH-1:WIDTH];
        r_c       <= (w_mul_prod[2*WIDTH-1:WIDTH] != '0);
        r_z       <= (w_mul_prod == '0);
        r_n       <= 1'b0;
        r_v       <= 1'b0;
      end
      // Pending multiply write-back survives only while the sequencer holds EXEC_B
      if (w_mul_start) begin
        r_wb_pend <= 1'b1;
      end else if (state != EXEC_B) begin
        r_wb_pend <= 1'b0;
      end else if (!w_busy && r_wb_pend) begin
        r_acc     <= r_latch;
        r_wb_pend <= 1'b0;
      end
`endif
    end
  end

  assign acc   = r_acc;
  assign latch = r_latch;
  assign c     = r_c;
  assign z     = r_z;
  assign n     = r_n;
  assign v     = r_v;
  assign busy  = w_busy;
  assign d_out = r_acc;
  assign d_oe  = (state == EXEC_B) && (w_op == OP_ST);

endmodule

// File: tb/tb_alu_gen.sv
// tb_alu_gen: self-checking bench for alu_gen (WIDTH=8), with or without ALU_MUL_EN.
module tb_alu_gen;
  import alu_gen_pkg::*;

  localparam int     W   = 8;
  localparam longint MOD = longint'(1) << W;
`ifdef ALU_MUL_EN
  localparam int MUL_CYC = W;
`else
  localparam int MUL_CYC = 0;
`endif

  localparam logic [7:0] I_ADD = 8'h00, I_SUB = 8'h20, I_NAND = 8'h40;
  localparam logic [7:0] I_SHR = 8'h7F, I_SHL = 8'h60, I_LD = 8'h80;
  localparam logic [7:0] I_ST  = 8'hA0, I_MUL = 8'hC0, I_ADC = 8'hE0;

  // ---------------- clock / reset / DUT ----------------
  logic         tclk = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   instruction = 8'h00;
  logic [1:0]   state = FETCH;
  logic [W-1:0] d_in = '0;
  logic [W-1:0] d_out, acc, latch, prod_hi;
  logic         d_oe, c, z, n, v, busy;

  always #5 tclk = ~tclk;

  alu_gen #(.WIDTH(W)) dut (
    .tclk(tclk), .reset_n(reset_n), .instruction(instruction), .state(state),
    .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .acc(acc), .latch(latch),
    .prod_hi(prod_hi), .c(c), .z(z), .n(n), .v(v), .busy(busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_acc, m_latch, m_ph;
  logic         m_c, m_z, m_n, m_v;

  function automatic longint sgn(input longint x);
    return (x >= MOD / 2) ? x - MOD : x;
  endfunction

  task automatic model_reset();
    m_acc = '0; m_latch = '0; m_ph = '0;
    m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
  endtask

  // Effect of one complete FETCH..EXEC_B instruction
  task automatic model_exec(input logic [7:0] instr, input logic [W-1:0] din);
    longint a, b, r, full, sr, cin;
    logic   alu;
    a = longint'(m_acc); b = longint'(din);
    r = 0; sr = 0; alu = 1'b1;
    case (instr[7:5])
      3'b000, 3'b111: begin
        cin  = (instr[7:5] == 3'b111) ? longint'(m_c) : 0;
        full = a + b + cin;
        r    = full % MOD;
        m_c  = (full >= MOD);
        sr   = sgn(a) + sgn(b) + cin;
      end
      3'b001: begin
        r   = (a - b + MOD) % MOD;
        m_c = (a < b);
        sr  = sgn(a) - sgn(b);
      end
      3'b010: begin
        r   = (MOD - 1) - (a & b);
        m_c = 1'b0;
      end
      3'b011: begin
        if (instr[4:0] == 5'h1F) begin
          r = a / 2; m_c = ((a % 2) != 0);
        end else begin
          r = (a * 2) % MOD; m_c = (a >= MOD / 2);
        end
      end
      3'b100: begin
        m_acc = din; alu = 1'b0;
      end
      3'b110: begin
        alu = 1'b0;
`ifdef ALU_MUL_EN
        full    = a * b;
        m_latch = W'(full % MOD);
        m_ph    = W'(full / MOD);
        m_c     = (m_ph != '0);
        m_z     = (full == 0);
        m_n     = 1'b0;
        m_v     = 1'b0;
        m_acc   = m_latch;
`endif
      end
      default: alu = 1'b0;
    endcase
    if (alu) begin
      m_latch = W'(r);
      m_z     = (r == 0);
      m_n     = (r >= MOD / 2);
      m_v     = (sr > MOD / 2 - 1) || (sr < -(MOD / 2));
      m_acc   = m_latch;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".acc"},     acc,            m_acc);
    check({tag, ".latch"},   latch,          m_latch);
    check({tag, ".prod_hi"}, prod_hi,        m_ph);
    check({tag, ".flags"},   {c, z, n, v},   {m_c, m_z, m_n, m_v});
    check({tag, ".busy"},    busy,           1'b0);
  endtask

  // ---------------- driver ----------------
  logic [W-1:0] a_latch, a_acc, b_latch, b_acc, b_ph, st_dout;
  logic [3:0]   a_flags, b_flags, oe_mask;
  logic         a_busy;
  int           busy_cycles;

  task automatic tick();
    @(posedge tclk); #1;
  endtask

  task automatic phase(input logic [1:0] st);
    state = st;
    #1;
    oe_mask[st] = d_oe;
    if (st == EXEC_B) st_dout = d_out;
    tick();
  endtask

  // One full instruction; holds EXEC_B while busy, scrambling inputs meanwhile
  task automatic run_op(input logic [7:0] instr, input logic [W-1:0] din);
    instruction = instr; d_in = din; oe_mask = '0; busy_cycles = 0;
    phase(FETCH); phase(DECODE); phase(EXEC_A);
    a_latch = latch; a_acc = acc; a_flags = {c, z, n, v}; a_busy = busy;
    state = EXEC_B;
    while (busy && busy_cycles < 4 * W) begin
      instruction = 8'($urandom);
      d_in = W'($urandom);
      tick();
      busy_cycles++;
    end
    b_latch = latch; b_acc = acc; b_ph = prod_hi; b_flags = {c, z, n, v};
    instruction = instr; d_in = din;
    phase(EXEC_B);
    state = FETCH;
  endtask

  task automatic do_op(input logic [7:0] instr, input logic [W-1:0] din);
    run_op(instr, din);
    model_exec(instr, din);
  endtask

  // acc = a0 and carry = cin, built from ordinary instructions
  task automatic setup(input logic [W-1:0] a0, input logic cin);
    do_op(I_LD, '0);
    if (cin) do_op(I_SUB, W'(1));
    else     do_op(I_ADD, '0);
    do_op(I_LD, a0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0]   instr;
    logic [W-1:0] acc0;
    logic [W-1:0] din;
    logic         cin;
    logic [W-1:0] e_latch;
    logic [3:0]   e_flags;  // {c, z, n, v}
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{I_ADD,  8'h7F, 8'h01, 1'b0, 8'h80, 4'b0011};
    vecs[1]  = '{I_SUB,  8'h05, 8'h05, 1'b0, 8'h00, 4'b0100};
    vecs[2]  = '{I_SUB,  8'h00, 8'h01, 1'b0, 8'hFF, 4'b1010};
    vecs[3]  = '{I_ADC,  8'hFF, 8'h00, 1'b1, 8'h00, 4'b1100};
    vecs[4]  = '{I_SHR,  8'h03, 8'h00, 1'b0, 8'h01, 4'b1000};
    vecs[5]  = '{I_SHL,  8'h81, 8'h00, 1'b0, 8'h02, 4'b1000};
    vecs[6]  = '{I_NAND, 8'hF0, 8'h0F, 1'b0, 8'hFF, 4'b0010};
    vecs[7]  = '{I_SUB,  8'h80, 8'h01, 1'b0, 8'h7F, 4'b0001};
    vecs[8]  = '{I_ADC,  8'h01, 8'h01, 1'b0, 8'h02, 4'b0000};
    vecs[9]  = '{I_ADD,  8'hFF, 8'h01, 1'b0, 8'h00, 4'b1100};
    vecs[10] = '{I_ADC,  8'h7F, 8'h00, 1'b1, 8'h80, 4'b0011};
    vecs[11] = '{I_SHR,  8'h80, 8'h00, 1'b0, 8'h40, 4'b0000};

    // Reset with a live ADD presented in EXEC_A: reset must win
    model_reset();
    reset_n = 1'b0; state = EXEC_A; instruction = I_ADD; d_in = 8'h05;
    tick(); tick();
    check_all("reset");
    check("reset.d_oe", d_oe, 1'b0);
    reset_n = 1'b1; state = FETCH;
    tick();

    // Table: latch/flags after EXEC_A, acc untouched until EXEC_B
    for (int i = 0; i < 12; i++) begin
      setup(vecs[i].acc0, vecs[i].cin);
      do_op(vecs[i].instr, vecs[i].din);
      check($sformatf("vec%0d.latch_a", i), a_latch, vecs[i].e_latch);
      check($sformatf("vec%0d.flags_a", i), a_flags, vecs[i].e_flags);
      check($sformatf("vec%0d.acc_a", i),   a_acc,   vecs[i].acc0);
      check($sformatf("vec%0d.acc_b", i),   acc,     vecs[i].e_latch);
      check($sformatf("vec%0d.oe", i),      oe_mask, 4'b0000);
    end

    // ST: drives acc only in EXEC_B, changes nothing
    do_op(I_LD, 8'hA5);
    do_op(I_ST, 8'h5A);
    check("st.oe_mask", oe_mask, 4'b1000);
    check("st.d_out",   st_dout, 8'hA5);
    check_all("st");

    // MUL 0x10 * 0x20
    do_op(I_LD, 8'h10);
    do_op(I_MUL, 8'h20);
    check("mul.busy_cycles", busy_cycles, MUL_CYC);
    check("mul.busy_a",      a_busy,      MUL_CYC != 0);
`ifdef ALU_MUL_EN
    check("mul.latch_done",  b_latch, 8'h00);
    check("mul.prod_hi",     b_ph,    8'h02);
    check("mul.flags_done",  b_flags, 4'b1000);
    check("mul.acc_before_wb", b_acc, 8'h10);
`endif
    check_all("mul");

    // Sequencer leaves EXEC_B mid-multiply: product lands, write-back skipped
    do_op(I_LD, 8'h03);
    instruction = I_MUL; d_in = 8'h05;
    phase(FETCH); phase(DECODE); phase(EXEC_A);
    state = FETCH;
    repeat (W + 2) tick();
`ifdef ALU_MUL_EN
    m_latch = 8'h0F; m_ph = '0; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0; m_v = 1'b0;
`endif
    check_all("mul_abandon");

    // Reset on the 4th busy cycle of a multiply
    do_op(I_LD, 8'h10);
    instruction = I_MUL; d_in = 8'h20;
    phase(FETCH); phase(DECODE); phase(EXEC_A);
    state = EXEC_B;
    tick(); tick(); tick();
    check("mul_rst.busy_before", busy, MUL_CYC != 0);
    reset_n = 1'b0;
    tick();
    model_reset();
    check_all("mul_rst");
    reset_n = 1'b1; state = FETCH;
    tick();
    do_op(I_LD, 8'h3C);
    check("mul_rst.ld_acc", acc, 8'h3C);
    check_all("mul_rst.ld");

    // Randomized instructions against the model
    for (int k = 0; k < 150; k++) begin
      logic [7:0]   instr;
      logic [W-1:0] din;
      instr = 8'($urandom);
      if (instr[7:5] == 3'b011 && $urandom_range(0, 1) == 1) instr[4:0] = 5'h1F;
      din = W'($urandom);
      do_op(instr, din);
      exp_q.push_back(m_latch);
      check($sformatf("rnd%0d.latch", k), latch, exp_q.pop_front());
      check($sformatf("rnd%0d.acc", k),   acc,   m_acc);
      check($sformatf("rnd%0d.flags", k), {c, z, n, v}, {m_c, m_z, m_n, m_v});
      check($sformatf("rnd%0d.prod_hi", k), prod_hi, m_ph);
      check($sformatf("rnd%0d.oe", k), oe_mask, (instr[7:5] == 3'b101) ? 4'b1000 : 4'b0000);
      check($sformatf("rnd%0d.busy_cycles", k), busy_cycles,
            (instr[7:5] == 3'b110) ? MUL_CYC : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_gen.md
# alu_gen

Parametrised successor to the team's 8-bit accumulator ALU for the four-phase (FETCH/DECODE/EXEC_A/EXEC_B) CPU core.
- Generalised to WIDTH-bit data.
- Adds carry-in addition (ADC), a signed-overflow flag, a negative flag and a separate store-data path.
- Optionally adds an iterative unsigned multiplier. While it runs, the ALU raises `busy` and the sequencer holds EXEC_B.

## Interface
- WIDTH, 8: data, accumulator and operand width; legal range 4 to 32.
- tclk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of tclk.
- instruction  input  8  current instruction; [7:5] opcode, [4:0] operand/mode field.
- state  input  2  sequencer phase: FETCH=00, DECODE=01, EXEC_A=10, EXEC_B=11.
- d_in  input  WIDTH  operand from memory/data bus.
- d_out  output  WIDTH  store data; equals acc.
- d_oe  output  1  drive enable for d_out; the top level builds the tri-state.
- acc  output  WIDTH  accumulator register.
- latch  output  WIDTH  result register.
- prod_hi  output  WIDTH  upper half of the last product; present only with ALU_MUL_EN.
- c, z, n, v  output  1 each  carry/borrow, zero, negative (result MSB), signed overflow.
- busy  output  1  multiply in progress; the sequencer must stay in EXEC_B while high.

## Operation
- Opcodes [7:5]:
  - 000 ADD: acc+d_in
  - 001 SUB: acc-d_in
  - 010 NAND: ~(acc&d_in)
  - 011 SHIFT: right if [4:0]==5'h1F, else left; logical, operand ignored
  - 100 LD
  - 101 ST
  - 110 MUL
  - 111 ADC: acc+d_in+c
- Arithmetic/logic ops (000–011, 111): at the edge ending EXEC_A, latch <= result and flags update. At the edge ending EXEC_B, acc <= latch (write-back).
- Flags:
  - c: ADD/ADC carry-out; SUB borrow (1 when acc < d_in, unsigned); SHIFT the bit shifted out; NAND 0.
  - v: signed overflow for ADD/SUB/ADC; 0 for NAND/SHIFT.
  - z, n: computed from the WIDTH-bit result.
- LD: acc <= d_in at the edge ending EXEC_A; flags and latch unchanged.
- ST: d_oe=1 and d_out=acc combinationally throughout EXEC_B; no register changes. d_oe=0 at all other times.
- MUL: at the edge ending EXEC_A, the opcode, acc and d_in are captured, busy rises and a shift-add runs for WIDTH cycles.
  - On completion: latch <= product[WIDTH-1:0], prod_hi <= product[2W-1:W], z = (full product == 0), c = (high half != 0), n = v = 0; busy falls.
  - Write-back acc <= latch happens at the first EXEC_B edge with busy=0.
- Instruction/d_in changes while busy are ignored.
- If state leaves EXEC_B while busy (sequencer violation), the multiply still completes but write-back is skipped.
- FETCH/DECODE: no register changes.

## Timing
- Reset: the edge with reset_n=0 zeroes acc, latch, prod_hi, c, z, n, v, busy, the iteration counter and multiplier internals. Reset has priority over any operation, including mid-multiply.
- Single-cycle ops: result visible on latch/flags one edge after EXEC_A; on acc one edge after EXEC_B.
- MUL latency: busy is high for exactly WIDTH cycles starting the cycle after EXEC_A. latch/prod_hi are valid the cycle busy falls.
- d_out/d_oe are purely combinational from state, instruction and acc.

## Configuration
- ALU_MUL_EN defined: multiplier, prod_hi and busy behave as above.
- ALU_MUL_EN undefined:
  - Opcode 110 is a NOP (no register or flag change).
  - busy is tied 0 and prod_hi is tied 0.
  - No multiplier logic is synthesised.

## Structure
- Shared package alu_gen_pkg holds:
  - opcode constants (OP_ADD … OP_ADC)
  - phase encodings FETCH/DECODE/EXEC_A/EXEC_B
  - the SHIFT_RIGHT_CODE 5'h1F constant
- One sub-module, alu_gen_mul: iterative WIDTH×WIDTH shift-add multiplier with start/busy/done handshake; instantiated only under ALU_MUL_EN.

## Test plan
- WIDTH=8, acc=0x7F, ADD, d_in=0x01 -> after EXEC_A: latch=0x80, c=0, z=0, n=1, v=1; after EXEC_B: acc=0x80.
- acc=0x05, SUB, d_in=0x05 -> latch=0x00, z=1, c=0, v=0. Then acc=0x00, SUB, d_in=0x01 -> latch=0xFF, c=1, n=1.
- c=1, acc=0xFF, ADC, d_in=0x00 -> latch=0x00, c=1, z=1. Right SHIFT (instruction 0x7F) with acc=0x03 -> latch=0x01, c=1.
- ST with acc=0xA5 -> d_oe=1 and d_out=0xA5 only during EXEC_B; acc, latch and flags unchanged.
- ALU_MUL_EN, acc=0x10, MUL, d_in=0x20 -> busy high 8 cycles; then latch=0x00, prod_hi=0x02, c=1, z=0; acc=0x00 after write-back. Without the macro -> no change, busy=0.
- reset_n=0 on the 4th cycle of a MUL -> next cycle busy=0 and all registers/flags 0. A following LD with d_in=0x3C -> acc=0x3C.
